seq_detect_param: RTL

Parametrised Moore sequence detector. It generalises the fixed 5-bit "11011" detector to any pattern of 1..16 bits, with selectable overlapping or non-overlapping mode. It adds an input qualifier, a saturating match counter and a count clear. It sits on a serial bit stream and flags each complete pattern occurrence to downstream control logic.

---
 rtl/seq_detect_pkg.sv | 67 ++++++
 rtl/seq_detect_param_counter.sv | 43 ++++
 rtl/seq_detect_param.sv | 72 +++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sequence detector.
// next_state() builds the KMP-style transition table from the pattern literal.
package seq_detect_pkg;

  localparam int MAX_SEQ_LEN = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bit j of the pattern counted from the first-received (MSB) end.
  function automatic logic pat_bit(input logic [MAX_SEQ_LEN-1:0] pattern, input int len,
                                   input int j);
    return pattern[len-1-j];
  endfunction

  // Length of the longest proper prefix of the pattern that is also its suffix.
  function automatic int fail_len(input logic [MAX_SEQ_LEN-1:0] pattern, input int len);
    int  f;
    logic ok;
    f = 0;
    for (int k = 1; k < MAX_SEQ_LEN; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_SEQ_LEN; i++) begin
          if (i < k && pattern[len-1-i] != pattern[k-1-i]) ok = 1'b0;
        end
        if (ok) f = k;
      end
    end
    return f;
  endfunction

  function automatic int next_state(input logic [MAX_SEQ_LEN-1:0] pattern, input int len,
                                    input int state, input logic in_bit, input int overlap);
    int   s;
    int   best;
    int   j;
    logic c;
    logic ok;
    if (state >= len) s = (overlap != 0) ? fail_len(pattern, len) : 0;
    else              s = state;
    best = 0;
    // Consumed string is the first s pattern bits followed by in_bit; keep the longest
    // pattern prefix that is a suffix of it.
    for (int k = 1; k <= MAX_SEQ_LEN; k++) begin
      if (k <= s + 1 && k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_SEQ_LEN; i++) begin
          if (i < k) begin
            j = s + 1 - k + i;
            c = (j < s) ? pat_bit(pattern, len, j) : in_bit;
            if (c != pat_bit(pattern, len, i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_param_counter.sv
// Saturating match counter with a sticky all-ones flag and a synchronous clear.
module seq_match_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      sat_d = sat_q | (&cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Moore detector for an arbitrary 1..16-bit pattern; state is the matched prefix length
// and the transition table is fixed at elaboration from PATTERN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               SEQ_LEN = 5,
  parameter logic [SEQ_LEN-1:0] PATTERN = 5'b11011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                     SW       = clog2(SEQ_LEN + 1);
  localparam logic [SW-1:0]          MATCH_ST = SW'(SEQ_LEN);
  localparam logic [MAX_SEQ_LEN-1:0] PAT_EXT  = MAX_SEQ_LEN'(PATTERN);

  if (SEQ_LEN < 1 || SEQ_LEN > MAX_SEQ_LEN || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: SEQ_LEN must be 1..16 and CNT_W at least 1");
  end

  logic [SW-1:0] tbl0 [SEQ_LEN+1];
  logic [SW-1:0] tbl1 [SEQ_LEN+1];

  for (genvar gi = 0; gi <= SEQ_LEN; gi++) begin : g_tbl
    localparam logic [SW-1:0] NS0 = SW'(next_state(PAT_EXT, SEQ_LEN, gi, 1'b0, int'(OVERLAP)));
    localparam logic [SW-1:0] NS1 = SW'(next_state(PAT_EXT, SEQ_LEN, gi, 1'b1, int'(OVERLAP)));
    assign tbl0[gi] = NS0;
    assign tbl1[gi] = NS1;
  end

  logic [SW-1:0] state_q, state_d;
  logic          match_inc;

  always_comb begin
    state_d   = state_q;
    match_inc = 1'b0;
    // Unreachable encodings recover to the idle state regardless of in_valid.
    if (state_q > MATCH_ST) begin
      state_d = '0;
    end else if (in_valid) begin
      state_d   = in ? tbl1[state_q] : tbl0[state_q];
      match_inc = (state_d == MATCH_ST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign out = (state_q == MATCH_ST);

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk(clk),
    .rst(rst),
    .inc(match_inc),
    .clr(clr_cnt),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule
